pipe_hazard_ctl: RTL and testbench

Parametrised pipeline hazard and boot controller for the MIPS core family. It turns per-stage hazard requests into per-stage stall and flush vectors for an in-order pipeline of STAGES stages, using a fixed priority order. It also tracks the previous-cycle fetch stall to tell a pure branch apart from a branch onto a stalled delay slot, and holds a boot jump after reset. Optional saturating per-cause stall counters are available for profiling. It sits at core top level, between the stage modules.

---
 rtl/pipe_hazard_ctl_if.sv | 41 ++++
 rtl/pipe_hazard_ctl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctl_if.sv
// Hazard/redirect bundle between the pipeline stages and pipe_hazard_ctl.
//   master : stage side, drives hazard requests and branch info, receives
//            stall/flush vectors and the fetch redirect.
//   slave  : pipe_hazard_ctl side.
// Signals:
//   sx_haz      structural busy, bit k-2 = stage k (k = 2..STAGES-2)
//   i_haz       fetch memory busy
//   war_haz     decode operand hazard
//   br_jump     taken branch resolved in stage 2
//   br_target   branch target
//   annul       annul delay slot
//   stall       per-stage freeze, stages 0..STAGES-1
//   flush       per-stage bubble insert, stages 0..STAGES-2
//   jump        fetch redirect
//   jump_target redirect address
//   booting     boot hold active
interface pipe_hazard_ctl_if #(
  parameter int STAGES = 5
);
  logic [STAGES-4:0] sx_haz;
  logic              i_haz;
  logic              war_haz;
  logic              br_jump;
  logic [31:0]       br_target;
  logic              annul;
  logic [STAGES-1:0] stall;
  logic [STAGES-2:0] flush;
  logic              jump;
  logic [31:0]       jump_target;
  logic              booting;

  modport master (
    output sx_haz, i_haz, war_haz, br_jump, br_target, annul,
    input  stall, flush, jump, jump_target, booting
  );

  modport slave (
    input  sx_haz, i_haz, war_haz, br_jump, br_target, annul,
    output stall, flush, jump, jump_target, booting
  );
endinterface

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard and boot controller.
// Converts per-stage hazard requests into stall/flush vectors using a fixed
// priority (structural > fetch busy > pure branch > WAR), tracks the previous
// cycle's fetch stall so a branch onto a stalled delay slot freezes fetch
// instead of flushing it, and forces a boot jump for BOOT_HOLD cycles after
// reset release.
// Ports:
//   clk       core clock
//   rst       synchronous reset, active low
//   hz        hazard/redirect bundle (slave side), see pipe_hazard_ctl_if
//   perf_sel  profiling counter select (0..5 valid, 6..7 read 0)
//   perf_clr  clear all profiling counters
//   perf_cnt  selected profiling counter, registered
// Build option: define HAZARD_CTL_PERF_EN to include the saturating per-cause
// stall counters; without it perf_cnt is tied to 0.
module pipe_hazard_ctl #(
  parameter int          STAGES      = 5,
  parameter int          BOOT_HOLD   = 10,
  parameter logic [31:0] BOOT_VECTOR = 32'hBFC00000,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctl_if.slave hz,
  input  logic [2:0]       perf_sel,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] perf_cnt
);

  localparam int IDX_W = $clog2(STAGES);
  localparam int BC_W  = $clog2(BOOT_HOLD + 1);
  localparam logic [BC_W-1:0]   HOLD_C = BC_W'(BOOT_HOLD);
  localparam logic [STAGES-1:0] ONE_S  = STAGES'(1);

  logic              stall0_q;
  logic [BC_W-1:0]   boot_cnt;
  logic [STAGES-1:0] stall_v;
  logic [STAGES-2:0] flush_v;
  logic              sx_hit;
  logic [IDX_W-1:0]  sx_idx;
  logic              pure_br;
  logic              war;
  logic              win_sx, win_i, win_br, win_war;
  logic              booting_v;

  assign pure_br = hz.br_jump & ~stall0_q;
  // A branch right after a fetch stall lands on a frozen delay slot; it is
  // handled like an operand hazard so fetch is held rather than flushed.
  assign war     = hz.war_haz | (hz.br_jump & stall0_q);

  always_comb begin
    stall_v = '0;
    flush_v = '0;
    sx_hit  = 1'b0;
    sx_idx  = '0;
    win_sx  = 1'b0;
    win_i   = 1'b0;
    win_br  = 1'b0;
    win_war = 1'b0;
    // Later iterations overwrite, so the highest busy stage wins.
    for (int i = 0; i < STAGES - 3; i++) begin
      if (hz.sx_haz[i]) begin
        sx_hit = 1'b1;
        sx_idx = IDX_W'(i + 2);
      end
    end
    if (sx_hit) begin
      win_sx  = 1'b1;
      stall_v = ~(ONE_S << sx_idx);
    end else if (hz.i_haz) begin
      win_i      = 1'b1;
      stall_v[1] = 1'b1;
      flush_v[2] = 1'b1;
    end else if (pure_br) begin
      win_br       = 1'b1;
      flush_v[1:0] = 2'b11;
    end else if (war) begin
      win_war    = 1'b1;
      stall_v[0] = 1'b1;
      flush_v[1] = 1'b1;
    end
    if (hz.annul) flush_v[2:0] = 3'b111;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall0_q <= 1'b0;
      boot_cnt <= '0;
    end else begin
      stall0_q <= stall_v[0];
      if (boot_cnt != HOLD_C) boot_cnt <= boot_cnt + 1'b1;
    end
  end

  // Held in boot while reset is low too, independent of the counter's
  // pre-reset contents.
  assign booting_v      = ~rst | (boot_cnt != HOLD_C);
  assign hz.stall       = stall_v;
  assign hz.flush       = flush_v;
  assign hz.booting     = booting_v;
  assign hz.jump        = booting_v ? 1'b1 : hz.br_jump;
  assign hz.jump_target = booting_v ? BOOT_VECTOR : hz.br_target;

`ifdef HAZARD_CTL_PERF_EN
  logic [CNT_W-1:0] cnt [6];
  logic [CNT_W-1:0] sel_val;
  logic [5:0]       ev;

  assign ev = {1'b1, hz.annul, win_war, win_br, win_i, win_sx};

  always_comb begin
    sel_val = '0;
    case (perf_sel)
      3'd0:    sel_val = cnt[0];
      3'd1:    sel_val = cnt[1];
      3'd2:    sel_val = cnt[2];
      3'd3:    sel_val = cnt[3];
      3'd4:    sel_val = cnt[4];
      3'd5:    sel_val = cnt[5];
      default: sel_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_cnt <= '0;
      for (int i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      perf_cnt <= sel_val;
      for (int i = 0; i < 6; i++) begin
        if (perf_clr)                        cnt[i] <= '0;
        else if (ev[i] && (cnt[i] != '1))    cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
`else
  logic unused_perf;
  assign unused_perf = ^{perf_sel, perf_clr, win_sx, win_i, win_br, win_war};
  assign perf_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
module tb_pipe_hazard_ctl;
  localparam int          STAGES    = 5;
  localparam int          BOOT_HOLD = 10;
  localparam logic [31:0] BOOT_VEC  = 32'hBFC00000;
  localparam int          CNT_W     = 4;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  typedef struct {
    logic        rst;
    logic [1:0]  sx;
    logic        i;
    logic        war;
    logic        br;
    logic [31:0] tgt;
    logic        annul;
    logic [2:0]  sel;
    logic        clr;
  } stim_t;

  typedef struct {
    int          stall;
    int          flush;
    logic        jump;
    logic [31:0] tgt;
    logic        boot;
    int          perf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       perf_sel;
  logic             perf_clr;
  logic [CNT_W-1:0] perf_cnt;

  pipe_hazard_ctl_if #(.STAGES(STAGES)) hz ();

  pipe_hazard_ctl #(
    .STAGES(STAGES), .BOOT_HOLD(BOOT_HOLD), .BOOT_VECTOR(BOOT_VEC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .hz(hz),
    .perf_sel(perf_sel), .perf_clr(perf_clr), .perf_cnt(perf_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  // reference model state
  logic m_prev_s0;
  int   m_boot;
  int   m_cnt[6];
  int   m_perf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Priority resolution straight from the hazard rules.
  // win: 0 structural, 1 fetch busy, 2 pure branch, 3 WAR, -1 none
  function automatic void resolve(input stim_t s, input logic prev,
                                  output int st, output int fl, output int win);
    int top = -1;
    st = 0; fl = 0; win = -1;
    for (int k = 2; k <= STAGES - 2; k++) if (s.sx[k-2]) top = k;
    if (top >= 0) begin
      win = 0; st = ((1 << STAGES) - 1) - (1 << top);
    end else if (s.i) begin
      win = 1; st = 2; fl = 4;
    end else if (s.br && !prev) begin
      win = 2; fl = 3;
    end else if (s.war || (s.br && prev)) begin
      win = 3; st = 1; fl = 2;
    end
    if (s.annul) fl = fl | 7;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    int   st, fl, win;
    @(posedge clk);
    #1;
    rst          = s.rst;
    hz.sx_haz    = s.sx;
    hz.i_haz     = s.i;
    hz.war_haz   = s.war;
    hz.br_jump   = s.br;
    hz.br_target = s.tgt;
    hz.annul     = s.annul;
    perf_sel     = s.sel;
    perf_clr     = s.clr;

    resolve(s, m_prev_s0, st, fl, win);
    e.stall = st;
    e.flush = fl;
    e.boot  = !s.rst || (m_boot < BOOT_HOLD);
    e.jump  = e.boot ? 1'b1 : s.br;
    e.tgt   = e.boot ? BOOT_VEC : s.tgt;
`ifdef HAZARD_CTL_PERF_EN
    e.perf  = m_perf;
`else
    e.perf  = 0;
`endif
    exp_q.push_back(e);

    // advance model to the next cycle
    m_prev_s0 = s.rst ? st[0] : 1'b0;
    m_boot    = !s.rst ? 0 : (m_boot < BOOT_HOLD ? m_boot + 1 : BOOT_HOLD);
    if (!s.rst) begin
      m_perf = 0;
      for (int c = 0; c < 6; c++) m_cnt[c] = 0;
    end else begin
      m_perf = (s.sel < 6) ? m_cnt[s.sel] : 0;
      for (int c = 0; c < 6; c++) begin
        bit ev;
        ev = (c == 5) || (c == 4 && s.annul) || (c < 4 && win == c);
        if (s.clr)                      m_cnt[c] = 0;
        else if (ev && m_cnt[c] < CNT_MAX) m_cnt[c] = m_cnt[c] + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall",       32'(hz.stall),    32'(e.stall));
      check("flush",       32'(hz.flush),    32'(e.flush));
      check("jump",        32'(hz.jump),     32'(e.jump));
      check("jump_target", hz.jump_target,   e.tgt);
      check("booting",     32'(hz.booting),  32'(e.boot));
      check("perf_cnt",    32'(perf_cnt),    32'(e.perf));
    end
  end

  function automatic stim_t mk(logic r, logic [1:0] sx, logic i, logic war, logic br,
                               logic annul, logic [2:0] sel, logic clr);
    stim_t s;
    s.rst = r; s.sx = sx; s.i = i; s.war = war; s.br = br;
    s.tgt = $urandom; s.annul = annul; s.sel = sel; s.clr = clr;
    return s;
  endfunction

  initial begin
    rst = 1'b0; hz.sx_haz = '0; hz.i_haz = 0; hz.war_haz = 0; hz.br_jump = 0;
    hz.br_target = '0; hz.annul = 0; perf_sel = '0; perf_clr = 0;
    repeat (2) @(posedge clk);
    m_prev_s0 = 1'b0; m_boot = 0; m_perf = 0;
    for (int c = 0; c < 6; c++) m_cnt[c] = 0;

    // reset with hazards present, then release and ride through boot hold
    apply(mk(0, 2'b00, 0, 0, 0, 0, 3'd5, 0));
    apply(mk(0, 2'b00, 1, 0, 0, 0, 3'd5, 0));
    apply(mk(0, 2'b00, 0, 0, 1, 0, 3'd5, 0));
    for (int c = 0; c < 14; c++) apply(mk(1, 2'b00, 0, 0, c[0], 0, 3'd5, 0));

    // structural priority, fetch busy, branch vs. branch-after-stall, annul
    apply(mk(1, 2'b11, 1, 1, 0, 0, 3'd0, 0));
    apply(mk(1, 2'b00, 1, 0, 0, 0, 3'd1, 0));
    apply(mk(1, 2'b00, 0, 0, 0, 0, 3'd2, 0));
    apply(mk(1, 2'b00, 0, 0, 1, 0, 3'd2, 0));
    apply(mk(1, 2'b00, 0, 1, 0, 0, 3'd3, 0));
    apply(mk(1, 2'b00, 0, 1, 1, 0, 3'd3, 0));
    apply(mk(1, 2'b00, 0, 0, 1, 0, 3'd3, 0));
    apply(mk(1, 2'b01, 0, 0, 0, 1, 3'd4, 0));
    apply(mk(1, 2'b00, 1, 0, 1, 0, 3'd1, 0));

    // counter saturation then clear together with an event
    for (int c = 0; c < 20; c++) apply(mk(1, 2'b00, 0, 1, 0, 0, 3'd3, 0));
    apply(mk(1, 2'b00, 0, 1, 0, 0, 3'd3, 1));
    apply(mk(1, 2'b00, 0, 0, 0, 0, 3'd3, 0));
    apply(mk(1, 2'b00, 0, 0, 0, 0, 3'd6, 0));
    apply(mk(1, 2'b00, 0, 0, 0, 0, 3'd7, 0));

    // mid-run reset restarts boot hold
    apply(mk(0, 2'b00, 0, 1, 0, 0, 3'd5, 0));
    for (int c = 0; c < 12; c++) apply(mk(1, 2'b00, 0, 0, 1, 0, 3'd5, 0));

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      stim_t s;
      s = mk(($urandom_range(0, 79) != 0),
             {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)},
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
             3'($urandom_range(0, 7)), ($urandom_range(0, 39) == 0));
      apply(s);
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
